// File: rtl/route_request_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// | Package : train_ctrl_pkg                                                |
// | Shared route ID width/limits, route constants and sequencer state type  |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

package train_ctrl_pkg;

    localparam int ROUTE_W         = 5;
    localparam int ROUTE_MAX_VALID = 15;

    typedef logic [ROUTE_W-1:0] route_id_t;

    // Route IDs understood by the track-section synchronizer
    localparam route_id_t ROUTE_ID_NONE  = 5'd0;
    localparam route_id_t ROUTE_ID_FIRST = 5'd0;
    localparam route_id_t ROUTE_ID_LAST  = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_GRANTED = 3'd5,
        ST_DENY    = 3'd6
    } seq_state_t;

    function automatic logic route_is_valid(input route_id_t id);
        return id <= route_id_t'(ROUTE_MAX_VALID);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/route_request_sequencer_if.sv
// ---------------------------------------------------------------------------
// | Interface : route_request_sequencer_if                                  |
// | Dispatcher and synchronizer handshake signals of the route sequencer    |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

interface route_request_sequencer_if;
    import train_ctrl_pkg::*;

    logic      ReqValid;
    route_id_t ReqRoute;
    logic      ReqReady;
    route_id_t Selector;
    logic      Enable;
    logic      SyncY;
    logic      Grant;
    route_id_t GrantRoute;
    logic      Deny;
    logic      Release;
    logic      Busy;

    // Sequencer side
    modport master (
        input  ReqValid, ReqRoute, SyncY, Release,
        output ReqReady, Selector, Enable, Grant, GrantRoute, Deny, Busy
    );

    // Dispatcher / synchronizer side
    modport slave (
        output ReqValid, ReqRoute, SyncY, Release,
        input  ReqReady, Selector, Enable, Grant, GrantRoute, Deny, Busy
    );

endinterface

`default_nettype wire

// File: rtl/cycle_timer.sv
// ---------------------------------------------------------------------------
// | Module : cycle_timer                                                    |
// | Loadable saturating down-counter; done while the count is zero          |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/route_request_sequencer.sv
// ---------------------------------------------------------------------------
// | Module : route_request_sequencer                                        |
// | Issues route requests to the synchronizer with settle, retry, backoff.  |
// | Optional macro ROUTE_WATCHDOG_EN revokes grants held too long.          |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module route_request_sequencer
    import train_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int MAX_RETRY       = 3,
    parameter int BACKOFF_CYCLES  = 16,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    route_request_sequencer_if.master bus
);

`ifdef ROUTE_WATCHDOG_EN
    localparam int TIMER_MAX = max_int(max_int(SETTLE_CYCLES, BACKOFF_CYCLES), WATCHDOG_CYCLES);
`else
    localparam int TIMER_MAX = max_int(SETTLE_CYCLES, BACKOFF_CYCLES);
`endif
    // Timer is loaded with N-1 so the full count range fits in clog2(N) bits
    localparam int TIMER_W = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
    localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RETRY_W-1:0] MAX_RETRY_C   = RETRY_W'(MAX_RETRY);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD   = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BACKOFF_LOAD  = TIMER_W'(BACKOFF_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1 || BACKOFF_CYCLES < 1 || MAX_RETRY < 0 || WATCHDOG_CYCLES < 1) begin : g_bad_params
            $error("route_request_sequencer: illegal parameter value");
        end
    endgenerate

    seq_state_t           state;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic                 timer_done;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_cycle_timer (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // Timer is armed on the edge that enters each timed state
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_ISSUE: begin
                timer_load  = 1'b1;
                timer_value = SETTLE_LOAD;
            end
            ST_SAMPLE: begin
`ifdef ROUTE_WATCHDOG_EN
                timer_load  = 1'b1;
                timer_value = bus.SyncY ? TIMER_W'(WATCHDOG_CYCLES - 1) : BACKOFF_LOAD;
`else
                timer_load  = !bus.SyncY;
                timer_value = BACKOFF_LOAD;
`endif
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    assign bus.ReqReady = (state == ST_IDLE) && Reset_n;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state          <= ST_IDLE;
            retry_cnt      <= '0;
            bus.Selector   <= '0;
            bus.Enable     <= 1'b0;
            bus.Grant      <= 1'b0;
            bus.GrantRoute <= '0;
            bus.Deny       <= 1'b0;
            bus.Busy       <= 1'b0;
        end else begin
            bus.Enable <= 1'b0;
            bus.Deny   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ReqValid) begin
                        retry_cnt <= '0;
                        bus.Busy  <= 1'b1;
                        if (route_is_valid(bus.ReqRoute)) begin
                            bus.Selector <= bus.ReqRoute;
                            bus.Enable   <= 1'b1;
                            state        <= ST_ISSUE;
                        end else begin
                            bus.Deny <= 1'b1;
                            state    <= ST_DENY;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (timer_done) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.SyncY) begin
                        bus.Grant      <= 1'b1;
                        bus.GrantRoute <= bus.Selector;
                        state          <= ST_GRANTED;
                    end else if (retry_cnt < MAX_RETRY_C) begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                        state     <= ST_BACKOFF;
                    end else begin
                        bus.Deny <= 1'b1;
                        state    <= ST_DENY;
                    end
                end
                ST_BACKOFF: begin
                    if (timer_done) begin
                        bus.Enable <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_GRANTED: begin
                    if (bus.Release) begin
                        bus.Grant      <= 1'b0;
                        bus.GrantRoute <= '0;
                        bus.Selector   <= '0;
                        bus.Busy       <= 1'b0;
                        state          <= ST_IDLE;
                    end
`ifdef ROUTE_WATCHDOG_EN
                    else if (timer_done) begin
                        // Revocation: grant dropped, dispatcher told via Deny
                        bus.Grant      <= 1'b0;
                        bus.GrantRoute <= '0;
                        bus.Deny       <= 1'b1;
                        state          <= ST_DENY;
                    end
`endif
                end
                ST_DENY: begin
                    bus.Selector <= '0;
                    bus.Busy     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    bus.Selector   <= '0;
                    bus.Grant      <= 1'b0;
                    bus.GrantRoute <= '0;
                    bus.Busy       <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_route_request_sequencer.sv
// ---------------------------------------------------------------------------
// | Testbench : tb_route_request_sequencer                                  |
// | Directed vectors with hand-computed cycle numbers (defaults, WD=8)      |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_route_request_sequencer;

    logic Clk;
    logic Reset_n;
    int   checks;
    int   failures;

    // Observation results, cycle 1 = cycle after the accepting edge
    int en_n;
    int en_cyc [8];
    int deny_n;
    int deny_cyc;
    int grant_first;
    int grant_last;

    route_request_sequencer_if bus_if ();

    route_request_sequencer #(
        .SETTLE_CYCLES   (4),
        .MAX_RETRY       (3),
        .BACKOFF_CYCLES  (16),
        .WATCHDOG_CYCLES (8)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check_value(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue_req(input int route);
        bus_if.ReqValid = 1'b1;
        bus_if.ReqRoute = 5'(route);
        tick();
        bus_if.ReqValid = 1'b0;
        bus_if.ReqRoute = '0;
    endtask

    // Samples outputs each cycle; raises SyncY after cycle sync_at, pulses Release in cycle rel_at
    task automatic observe(input int ncyc, input int sync_at, input int rel_at);
        en_n        = 0;
        deny_n      = 0;
        deny_cyc    = 0;
        grant_first = 0;
        grant_last  = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) tick();
            if (bus_if.Enable) begin
                if (en_n < 8) en_cyc[en_n] = c;
                en_n++;
            end
            if (bus_if.Deny) begin
                deny_n++;
                deny_cyc = c;
            end
            if (bus_if.Grant) begin
                if (grant_first == 0) grant_first = c;
                grant_last = c;
            end
            if (c == sync_at) bus_if.SyncY = 1'b1;
            bus_if.Release = (c == rel_at);
        end
        bus_if.Release = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_selector"},   int'(bus_if.Selector),   0);
        check_value({tag, "_enable"},     int'(bus_if.Enable),     0);
        check_value({tag, "_grant"},      int'(bus_if.Grant),      0);
        check_value({tag, "_grantroute"}, int'(bus_if.GrantRoute), 0);
        check_value({tag, "_deny"},       int'(bus_if.Deny),       0);
        check_value({tag, "_busy"},       int'(bus_if.Busy),       0);
    endtask

    task automatic do_release();
        bus_if.Release = 1'b1;
        tick();
        bus_if.Release = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus_if.ReqValid = 1'b0;
        bus_if.ReqRoute = '0;
        bus_if.SyncY    = 1'b0;
        bus_if.Release  = 1'b0;
        Reset_n = 1'b0;
        tick();
        tick();
        check_outputs_zero("reset");
        check_value("reset_ready", int'(bus_if.ReqReady), 0);
        Reset_n = 1'b1;
        tick();
        check_value("post_reset_ready", int'(bus_if.ReqReady), 1);

        // Route 6, first-try grant at cycle 7
        bus_if.SyncY = 1'b1;
        issue_req(6);
        check_value("r6_selector", int'(bus_if.Selector), 6);
        check_value("r6_busy",     int'(bus_if.Busy),     1);
        check_value("r6_ready",    int'(bus_if.ReqReady), 0);
        observe(9, -1, -1);
        check_value("r6_enable_n",   en_n,        1);
        check_value("r6_enable_cyc", en_cyc[0],   1);
        check_value("r6_grant_cyc",  grant_first, 7);
        check_value("r6_grant_held", grant_last,  9);
        check_value("r6_grantroute", int'(bus_if.GrantRoute), 6);
        do_release();
        check_value("r6_rel_grant",    int'(bus_if.Grant),    0);
        check_value("r6_rel_ready",    int'(bus_if.ReqReady), 1);
        check_value("r6_rel_selector", int'(bus_if.Selector), 0);
        check_value("r6_rel_busy",     int'(bus_if.Busy),     0);

        // Route 20 is out of range: immediate Deny, no Enable
        issue_req(20);
        check_value("r20_deny",     int'(bus_if.Deny),     1);
        check_value("r20_enable",   int'(bus_if.Enable),   0);
        check_value("r20_selector", int'(bus_if.Selector), 0);
        tick();
        check_value("r20_deny_gone", int'(bus_if.Deny),     0);
        check_value("r20_ready",     int'(bus_if.ReqReady), 1);

        // Route 10 refused every time: Enables at 1,23,45,67, Deny at 73
        bus_if.SyncY = 1'b0;
        issue_req(10);
        observe(80, -1, -1);
        check_value("r10_enable_n", en_n,      4);
        check_value("r10_en0",      en_cyc[0], 1);
        check_value("r10_en1",      en_cyc[1], 23);
        check_value("r10_en2",      en_cyc[2], 45);
        check_value("r10_en3",      en_cyc[3], 67);
        check_value("r10_deny_n",   deny_n,    1);
        check_value("r10_deny_cyc", deny_cyc,  73);
        check_value("r10_grant",    grant_first, 0);
        check_value("r10_ready",    int'(bus_if.ReqReady), 1);

        // Route 12, SyncY rises during second backoff: grant after 3rd SAMPLE (cycle 50)
        issue_req(12);
        observe(60, 40, -1);
        check_value("r12_enable_n",  en_n,        3);
        check_value("r12_grant_cyc", grant_first, 51);
        check_value("r12_deny_n",    deny_n,      0);
        check_value("r12_grantroute", int'(bus_if.GrantRoute), 12);
        do_release();
        check_value("r12_rel_ready", int'(bus_if.ReqReady), 1);

        // Reset during SETTLE
        bus_if.SyncY = 1'b1;
        issue_req(6);
        tick();
        check_value("rst_settle_busy", int'(bus_if.Busy), 1);
        Reset_n = 1'b0;
        tick();
        check_outputs_zero("rst_settle");
        Reset_n = 1'b1;
        tick();
        check_value("rst_settle_ready", int'(bus_if.ReqReady), 1);
        check_value("rst_settle_deny",  int'(bus_if.Deny),     0);

        // Reset during GRANTED
        issue_req(6);
        observe(8, -1, -1);
        check_value("rst_grant_pre", int'(bus_if.Grant), 1);
        Reset_n = 1'b0;
        tick();
        check_outputs_zero("rst_grant");
        Reset_n = 1'b1;
        tick();
        check_value("rst_grant_ready", int'(bus_if.ReqReady), 1);
        check_value("rst_grant_deny",  int'(bus_if.Deny),     0);

        // Route 0 granted without Release
        issue_req(0);
        observe(20, -1, -1);
        check_value("r0_grant_cyc", grant_first, 7);
`ifdef ROUTE_WATCHDOG_EN
        check_value("wd_grant_last", grant_last, 14);
        check_value("wd_deny_n",     deny_n,     1);
        check_value("wd_deny_cyc",   deny_cyc,   15);
        check_value("wd_ready",      int'(bus_if.ReqReady), 1);
        // Release in the expiry cycle wins over revocation
        issue_req(0);
        observe(20, -1, 14);
        check_value("wd_rel_grant_last", grant_last, 14);
        check_value("wd_rel_deny_n",     deny_n,     0);
        check_value("wd_rel_ready",      int'(bus_if.ReqReady), 1);
`else
        check_value("hold_grant_last", grant_last, 20);
        check_value("hold_deny_n",     deny_n,     0);
        do_release();
        check_value("hold_rel_ready", int'(bus_if.ReqReady), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/route_request_sequencer.md
# route_request_sequencer

Issuing side of the track-section synchronizer handshake. Accepts route requests from the dispatcher and drives `Selector` and `Enable` into the synchronizer. Samples the returned permission bit `SyncY` after a settle window, and retries with backoff while the section is occupied. Each request ends in either a held grant or a one-cycle denial to the dispatcher.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles between `Enable` pulse and `SyncY` sample (≥1)
- `MAX_RETRY`, 3: extra attempts after the first refusal (0 allowed)
- `BACKOFF_CYCLES`, 16: idle wait between attempts (≥1)
- `WATCHDOG_CYCLES`, 1024: grant hold limit, used only with `ROUTE_WATCHDOG_EN`

Ports:
- `Clk` in 1: single clock, all logic rising-edge
- `Reset_n` in 1: synchronous, active-low reset
- `ReqValid` in 1: dispatcher request valid
- `ReqRoute` in 5: requested route ID
- `ReqReady` out 1: high only in IDLE with `Reset_n`=1
- `Selector` out 5: route ID presented to synchronizer
- `Enable` out 1: one-cycle evaluate strobe to synchronizer
- `SyncY` in 1: synchronizer permission result
- `Grant` out 1: route granted, level
- `GrantRoute` out 5: ID of granted route, valid while `Grant`
- `Deny` out 1: one-cycle pulse, request refused or revoked
- `Release` in 1: dispatcher frees the granted route
- `Busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, ISSUE, SETTLE, SAMPLE, BACKOFF, GRANTED, DENY.
- IDLE: accept request when `ReqValid & ReqReady`. Latch `ReqRoute` and clear the retry counter.
- Route ID > 15: go directly to DENY. No `Enable` is issued.
- Otherwise go to ISSUE.
- ISSUE: `Enable`=1 for this cycle only, then SETTLE.
- `Selector` takes the latched route at entry to ISSUE. It stays stable until the return to IDLE, where it returns to 0.
- SETTLE: hold for `SETTLE_CYCLES` cycles, then SAMPLE.
- SAMPLE: `SyncY`=1 → GRANTED.
- SAMPLE: `SyncY`=0 and retries < `MAX_RETRY` → increment retries, then BACKOFF.
- SAMPLE: otherwise → DENY.
- BACKOFF: hold for `BACKOFF_CYCLES` cycles, then ISSUE. `SyncY` is ignored.
- GRANTED: `Grant`=1 and `GrantRoute`=latched route. On `Release`=1, go to IDLE; `Grant` drops the next cycle.
- DENY: `Deny`=1 for one cycle, then IDLE.
- `Release` is ignored outside GRANTED. `ReqValid` is ignored outside IDLE.
- Reset applies at any state, including mid-attempt or mid-grant. On the next edge: state IDLE, all registered outputs 0, no `Deny` pulse emitted.

## Timing
- Reset values: `Selector`=0, `Enable`=0, `Grant`=0, `GrantRoute`=0, `Deny`=0, `Busy`=0. `ReqReady`=0 while `Reset_n`=0, and 1 after reset.
- Request accepted at edge k:
  - `Enable` high during cycle k+1.
  - SAMPLE at cycle k+2+`SETTLE_CYCLES`.
  - First-try `Grant` high from k+3+`SETTLE_CYCLES` (k+7 with defaults).
- Invalid route: `Deny` high during cycle k+1.
- Each attempt takes `SETTLE_CYCLES`+2 cycles. Attempts are separated by `BACKOFF_CYCLES`.
- Final `Deny` appears the cycle after the last SAMPLE.
- `ReqReady` returns the cycle after DENY, or the cycle after `Release` is seen in GRANTED.
- Counters are sized by `$clog2` of the largest parameter they hold. No wrap-around is reachable.

## Configuration
- `ROUTE_WATCHDOG_EN` defined:
  - GRANTED counts cycles since entry.
  - After `WATCHDOG_CYCLES` cycles without `Release`: drop `Grant`, enter DENY (revocation pulse), then IDLE.
  - `Release` arriving in the same cycle as expiry wins: no `Deny`.
- Not defined: no counter is built, and the grant is held indefinitely.

## Structure
- Shared package `train_ctrl_pkg` holds:
  - the state enum;
  - `ROUTE_W`=5;
  - `ROUTE_MAX_VALID`=15;
  - the route ID constants shared with the synchronizer.
- One sub-module, `cycle_timer`: a loadable down-counter with a `done` flag. It is used for SETTLE, BACKOFF and the watchdog.

## Test plan
- Route 6, `SyncY`=1 held: `Enable` pulses once at k+1, `Grant`=1 and `GrantRoute`=6 at k+7. `Release` → `Grant`=0 next cycle, `ReqReady`=1.
- Route 20: `Deny` at k+1, no `Enable` pulse, `Selector` stays 0.
- Route 10, `SyncY`=0 always (defaults): 4 `Enable` pulses spaced 22 cycles apart, one `Deny` after the 4th SAMPLE, `Grant` never set.
- Route 12, `SyncY` rises before the 3rd SAMPLE: exactly 3 `Enable` pulses, then `Grant`=1.
- `Reset_n`=0 during SETTLE, and again during GRANTED: all outputs 0 next edge, no `Deny`, IDLE after reset.
- Build with `ROUTE_WATCHDOG_EN` and `WATCHDOG_CYCLES`=8, route 0 granted, no `Release`: `Grant` drops and `Deny` pulses 8 cycles after the grant.
